// File: rtl/pool2x2_feeder_if.sv
// pool2x2_feeder_if: groups the three streams around the 2x2 pooling feeder.
//   in_*    : raster-order pixel stream into the feeder (valid/ready)
//   pool_*  : drive/readback of the running-max pooler (en, Data_in, Data_out)
//   out_*   : pooled result stream out of the feeder (valid/ready, last)
// master = the feeder itself, slave = its surroundings (source, pooler, sink).
interface pool2x2_feeder_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              pool_en;
  logic [DATA_W-1:0] pool_data;
  logic [DATA_W-1:0] pool_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    input  in_valid, in_data, pool_result, out_ready,
    output in_ready, pool_en, pool_data, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, pool_result, out_ready,
    input  in_ready, pool_en, pool_data, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool2x2_feeder.sv
// pool2x2_feeder: buffers one row pair of a raster feature map, replays each
// 2x2 window to the running-max pooler as a 4-cycle en burst (TL, TR, BL, BR),
// captures the pooler result and emits it on a valid/ready stream.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pool2x2_feeder_if.master: in_valid/in_ready/in_data,
//          pool_en/pool_data/pool_result, out_valid/out_ready/out_data/out_last
module pool2x2_feeder #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAP_W  = 28,
  parameter int unsigned MAP_H  = 28
) (
  input  logic             clk,
  input  logic             rst,
  pool2x2_feeder_if.master bus
);

  localparam int unsigned FILL_N = 2 * MAP_W;
  localparam int unsigned FILL_W = $clog2(FILL_N);
  localparam int unsigned COL_N  = MAP_W / 2;
  localparam int unsigned COL_W  = (COL_N > 1) ? $clog2(COL_N) : 1;
  localparam int unsigned PAIR_N = MAP_H / 2;
  localparam int unsigned PAIR_W = (PAIR_N > 1) ? $clog2(PAIR_N) : 1;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    FEED     = 2'd1,
    CAPTURE  = 2'd2,
    WAIT_OUT = 2'd3
  } state_t;

  state_t              state_q, state_nx;
  logic [FILL_W-1:0]   fill_q, fill_nx;
  logic [COL_W-1:0]    col_q, col_nx;
  logic [1:0]          phase_q, phase_nx;
  logic [PAIR_W-1:0]   pair_q, pair_nx;

  logic                in_ready_nx;
  logic                pool_en_nx;
  logic [DATA_W-1:0]   pool_data_nx;
  logic                out_valid_nx;
  logic [DATA_W-1:0]   out_data_nx;
  logic                out_last_nx;

  // Row pair buffer: [0..MAP_W-1] is the upper row, [MAP_W..2*MAP_W-1] the lower.
  logic [DATA_W-1:0]   row_buf [FILL_N];

  logic                accept_c;
  logic                out_fire_c;
  logic                last_win_c;
  logic [FILL_W-1:0]   rd_idx_c;

  assign accept_c   = bus.in_valid & bus.in_ready;
  assign out_fire_c = bus.out_valid & bus.out_ready;
  assign last_win_c = (col_q == COL_W'(COL_N - 1)) && (pair_q == PAIR_W'(PAIR_N - 1));

  // Buffer address of the pixel presented next cycle: phase bit0 picks the
  // column within the window, phase bit1 picks the lower row.
  always_comb begin
    rd_idx_c = FILL_W'({col_nx, 1'b0}) + FILL_W'(phase_nx[0]);
    if (phase_nx[1]) begin
      rd_idx_c = rd_idx_c + FILL_W'(MAP_W);
    end
  end

  // Next-state, counters and next values of the registered outputs.
  always_comb begin
    state_nx     = state_q;
    fill_nx      = fill_q;
    col_nx       = col_q;
    phase_nx     = phase_q;
    pair_nx      = pair_q;
    out_valid_nx = bus.out_valid;
    out_data_nx  = bus.out_data;
    out_last_nx  = bus.out_last;

    unique case (state_q)
      FILL: begin
        if (accept_c) begin
          if (fill_q == FILL_W'(FILL_N - 1)) begin
            state_nx = FEED;
            fill_nx  = '0;
            col_nx   = '0;
            phase_nx = '0;
          end else begin
            fill_nx = fill_q + FILL_W'(1);
          end
        end
      end
      FEED: begin
        phase_nx = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        state_nx = WAIT_OUT;
      end
      WAIT_OUT: begin
        if (!bus.out_valid || bus.out_ready) begin
          if (col_q != COL_W'(COL_N - 1)) begin
            col_nx   = col_q + COL_W'(1);
            phase_nx = '0;
            state_nx = FEED;
          end else begin
            state_nx = FILL;
            fill_nx  = '0;
            col_nx   = '0;
            pair_nx  = (pair_q == PAIR_W'(PAIR_N - 1)) ? '0 : pair_q + PAIR_W'(1);
          end
        end
      end
      default: begin
        state_nx = FILL;
      end
    endcase

    // A capture always wins over a handshake landing on the same edge.
    if (state_q == CAPTURE) begin
      out_valid_nx = 1'b1;
      out_data_nx  = bus.pool_result;
      out_last_nx  = last_win_c;
    end else if (out_fire_c) begin
      out_valid_nx = 1'b0;
      out_last_nx  = 1'b0;
    end

    in_ready_nx  = (state_nx == FILL);
    pool_en_nx   = (state_nx == FEED);
    pool_data_nx = (state_nx == FEED) ? row_buf[rd_idx_c] : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      fill_q        <= '0;
      col_q         <= '0;
      phase_q       <= '0;
      pair_q        <= '0;
      bus.in_ready  <= 1'b0;
      bus.pool_en   <= 1'b0;
      bus.pool_data <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      state_q       <= state_nx;
      fill_q        <= fill_nx;
      col_q         <= col_nx;
      phase_q       <= phase_nx;
      pair_q        <= pair_nx;
      bus.in_ready  <= in_ready_nx;
      bus.pool_en   <= pool_en_nx;
      bus.pool_data <= pool_data_nx;
      bus.out_valid <= out_valid_nx;
      bus.out_data  <= out_data_nx;
      bus.out_last  <= out_last_nx;
    end
  end

  // Pixel storage; contents are don't-care after reset since filling restarts.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      row_buf[fill_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_pool2x2_feeder.sv
// tb_pool2x2_feeder: directed bench for pool2x2_feeder. A 4x4 instance covers
// reset, ordering, backpressure, gaps and window sweeps; a 28x28 instance runs
// two random frames against a 2x2 max reference. Both use a running-max pooler
// model that clears whenever en is low.
module tb_pool2x2_feeder;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  pool2x2_feeder_if #(.DATA_W(DW)) s ();
  pool2x2_feeder_if #(.DATA_W(DW)) b ();

  pool2x2_feeder #(.DATA_W(DW), .MAP_W(4), .MAP_H(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (s.master)
  );

  pool2x2_feeder #(.DATA_W(DW), .MAP_W(28), .MAP_H(28)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b.master)
  );

  // Pooler models: accumulate max while en, clear otherwise.
  always @(posedge clk or posedge rst) begin
    if (rst) s.pool_result <= '0;
    else if (s.pool_en) s.pool_result <= (s.pool_data > s.pool_result) ? s.pool_data : s.pool_result;
    else s.pool_result <= '0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) b.pool_result <= '0;
    else if (b.pool_en) b.pool_result <= (b.pool_data > b.pool_result) ? b.pool_data : b.pool_result;
    else b.pool_result <= '0;
  end

  // Monitors: sample 1 time unit after the falling edge.
  logic [31:0] feed_q [$];
  int          burst_q [$];
  logic [31:0] res_q [$];
  logic        last_q [$];
  logic [31:0] bres_q [$];
  logic        blast_q [$];
  int          s_run   = 0;
  int          overlap = 0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      s_run = 0;
    end else begin
      if (s.pool_en) begin
        feed_q.push_back(s.pool_data);
        s_run++;
      end else if (s_run != 0) begin
        burst_q.push_back(s_run);
        s_run = 0;
      end
      if (s.out_valid && s.out_ready) begin
        res_q.push_back(s.out_data);
        last_q.push_back(s.out_last);
      end
      if (s.in_ready && s.pool_en) overlap++;
      if (b.out_valid && b.out_ready) begin
        bres_q.push_back(b.out_data);
        blast_q.push_back(b.out_last);
      end
    end
  end

  logic [31:0] pix [2][784];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic clear_q();
    feed_q.delete();
    burst_q.delete();
    res_q.delete();
    last_q.delete();
  endtask

  // Push one pixel into the 4x4 instance; waited = cycles spent with in_ready=0.
  task automatic push_s(input logic [31:0] d, input bit gaps, output int waited);
    int n = 0;
    while (!s.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) tmo("in_ready_wait");
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        chk("gap_in_ready", 32'(s.in_ready), 1);
        tick();
      end
    end
    s.in_valid = 1'b1;
    s.in_data  = d;
    tick();
    s.in_valid = 1'b0;
    waited = n;
  endtask

  task automatic small_results(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    int n = 0;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    while (res_q.size() < 4 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) tmo({tag, "_wait"});
    chk({tag, "_count"}, 32'(res_q.size()), 4);
    for (int k = 0; k < 4 && k < res_q.size(); k++) begin
      chk($sformatf("%s_res%0d", tag, k), res_q[k], e[k]);
      chk($sformatf("%s_last%0d", tag, k), 32'(last_q[k]), (k == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int w;
    int n;
    int lasts;
    bit abort;
    logic [31:0] sweep [16];
    logic [31:0] m;
    logic [31:0] e;

    rst = 1'b1;
    s.in_valid = 1'b0; s.in_data = '0; s.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1;
    repeat (2) tick();

    // Values held during reset.
    chk("rst_in_ready",  32'(s.in_ready), 0);
    chk("rst_pool_en",   32'(s.pool_en), 0);
    chk("rst_pool_data", s.pool_data, 0);
    chk("rst_out_valid", 32'(s.out_valid), 0);
    chk("rst_out_data",  s.out_data, 0);
    chk("rst_out_last",  32'(s.out_last), 0);
    rst = 1'b0;
    tick();
    chk("release_in_ready", 32'(s.in_ready), 1);

    // Asynchronous reset in the middle of FEED.
    s.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_s(32'(i + 1), 1'b0, w);
    chk("midfeed_pool_en", 32'(s.pool_en), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pool_en",   32'(s.pool_en), 0);
    chk("arst_in_ready",  32'(s.in_ready), 0);
    chk("arst_out_valid", 32'(s.out_valid), 0);
    chk("arst_pool_data", s.pool_data, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst_release_in_ready", 32'(s.in_ready), 1);
    clear_q();

    // Frame 1: pixels 1..16, first result stalled for 10 cycles.
    s.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_s(32'(i + 1), 1'b0, w);
    n = 0;
    while (!s.out_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) tmo("first_result");
    for (int k = 0; k < 10; k++) begin
      chk("stall_out_data",  s.out_data, 6);
      chk("stall_out_valid", 32'(s.out_valid), 1);
      chk("stall_pool_en",   32'(s.pool_en), 0);
      tick();
    end
    s.out_ready = 1'b1;
    tick();
    chk("feed_after_hs_en",   32'(s.pool_en), 1);
    chk("feed_after_hs_data", s.pool_data, 3);
    for (int i = 8; i < 16; i++) push_s(32'(i + 1), 1'b0, w);
    small_results("f1", 6, 8, 14, 16);
    chk("f1_feed_count", 32'(feed_q.size()), 16);
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < 4; p++) begin
        e = 32'(((2 * (k / 2) + p / 2) * 4) + 2 * (k % 2) + (p % 2) + 1);
        if (k * 4 + p < feed_q.size()) chk($sformatf("f1_feed_w%0d_p%0d", k, p), feed_q[k * 4 + p], e);
      end
    end
    chk("f1_burst_count", 32'(burst_q.size()), 4);
    for (int k = 0; k < burst_q.size(); k++) chk($sformatf("f1_burst_len%0d", k), 32'(burst_q[k]), 4);

    // Frame 2: same pixels with random input gaps.
    clear_q();
    overlap = 0;
    for (int i = 0; i < 16; i++) begin
      push_s(32'(i + 1), 1'b1, w);
      if (i == 8) chk("gap_busy_pair0", 32'(w), 12);
    end
    n = 0;
    while (!s.in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("gap_busy_pair1", 32'(n), 12);
    small_results("f2", 6, 8, 14, 16);
    chk("f2_ready_during_feed", 32'(overlap), 0);
    for (int k = 0; k < burst_q.size(); k++) chk($sformatf("f2_burst_len%0d", k), 32'(burst_q[k]), 4);

    // Frame 3: maximum at each window position.
    clear_q();
    sweep = '{32'd9, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0,
              32'd0, 32'd0, 32'd0, 32'd0, 32'd9, 32'd0, 32'd0, 32'd9};
    for (int i = 0; i < 16; i++) push_s(sweep[i], 1'b0, w);
    small_results("sweep", 9, 9, 9, 9);

    // Frame 4: descending pixels, so a stale pooler value would show.
    clear_q();
    for (int i = 0; i < 16; i++) push_s(32'(16 - i), 1'b0, w);
    small_results("desc", 16, 14, 8, 6);

    // Two back-to-back random 28x28 frames.
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 784; i++) pix[f][i] = $urandom;
    abort = 1'b0;
    for (int f = 0; f < 2 && !abort; f++) begin
      for (int i = 0; i < 784 && !abort; i++) begin
        n = 0;
        while (!b.in_ready && n < 200) begin
          tick();
          n++;
        end
        if (n >= 200) begin
          tmo("big_in_ready_wait");
          abort = 1'b1;
        end else begin
          b.in_valid = 1'b1;
          b.in_data  = pix[f][i];
          tick();
        end
      end
    end
    b.in_valid = 1'b0;
    n = 0;
    while (bres_q.size() < 392 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) tmo("big_results_wait");
    chk("big_count", 32'(bres_q.size()), 392);
    lasts = 0;
    for (int k = 0; k < bres_q.size() && k < 392; k++) begin
      int f, wi, base;
      f    = k / 196;
      wi   = k % 196;
      base = (2 * (wi / 14)) * 28 + 2 * (wi % 14);
      m = pix[f][base];
      if (pix[f][base + 1]  > m) m = pix[f][base + 1];
      if (pix[f][base + 28] > m) m = pix[f][base + 28];
      if (pix[f][base + 29] > m) m = pix[f][base + 29];
      chk($sformatf("big_res%0d", k), bres_q[k], m);
      if (blast_q[k]) lasts++;
    end
    chk("big_last_count", 32'(lasts), 2);
    if (blast_q.size() >= 392) begin
      chk("big_last_f0", 32'(blast_q[195]), 1);
      chk("big_last_f1", 32'(blast_q[391]), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pool2x2_feeder.md
# pool2x2_feeder

Sequencer that drives the 2x2 max-pooling element (running-max register with `en`/`Data_in`/`Data_out`) from a raster-order convolution output stream. It buffers one row pair of the feature map and presents each 2x2 window to the pooler as a four-cycle `en` burst. It then samples the pooler's result and emits one pooled value per window on a valid/ready output stream. It sits between the ReLU'd convolution output and the pooler in each LeNet-5 subsampling stage.

## Interface
- `DATA_W`, 32: sample width (matches `INTERNAL_BITS`); values are treated as unsigned (post-ReLU).
- `MAP_W`, 28: feature-map width; must be even, ≥2.
- `MAP_H`, 28: feature-map height; must be even, ≥2.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  block can accept a pixel.
- `in_data`  in  DATA_W  input pixel, raster order (row-major, top-left first).
- `pool_en`  out  1  drives pooler `en`.
- `pool_data`  out  DATA_W  drives pooler `Data_in`.
- `pool_result`  in  DATA_W  pooler `Data_out`.
- `out_valid`  out  1  pooled result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  DATA_W  pooled result.
- `out_last`  out  1  qualifies `out_data` as the final result of the frame.

## Operation
- Row buffer: 2×MAP_W registers, row 0 and row 1 of the current pair.
- States: FILL, FEED, CAPTURE, WAIT_OUT.
- FILL: `in_ready`=1. Each cycle with `in_valid`=1 writes `in_data` to the buffer at the fill index and increments the index. After pixel 2·MAP_W−1 is accepted, the block goes to FEED with window column c=0 and phase p=0. FILL is allowed while `out_valid`=1 is pending.
- FEED: `in_ready`=0 and `pool_en`=1. `pool_data` follows phase order p=0..3 = buf[r0][2c], buf[r0][2c+1], buf[r1][2c], buf[r1][2c+1]. p increments each cycle. After p=3 the block goes to CAPTURE.
- CAPTURE: one cycle with `pool_en`=0. At this cycle's edge, `out_data`←`pool_result` (the max of the 4 values), `out_valid`←1, and `out_last`←1 if this is the last window of the last row pair. The block then goes to WAIT_OUT. The pooler clears itself at the same edge.
- WAIT_OUT: `pool_en`=0. It stays here while `out_valid`=1 and `out_ready`=0. When `out_valid`=0, or a handshake occurs this cycle:
  - if c < MAP_W/2−1: c++, go to FEED;
  - otherwise: go to FILL with the fill index cleared. The row-pair counter increments and wraps to 0 after MAP_H/2 pairs.
- Output handshake: on `out_valid`&`out_ready` at an edge, `out_valid`←0 and `out_last`←0, unless CAPTURE loads a new value at that same edge (CAPTURE loads take priority). By construction, `out_valid`=0 whenever CAPTURE executes.
- While not in FEED, `pool_data` holds 0.
- Comparison and width are both entirely in the pooler. This block does no arithmetic beyond its counters.
- Counter widths: clog2 of each range. No overflow is possible because every counter wraps exactly at its terminal count.

## Timing
- Reset values: `in_ready`=0, `pool_en`=0, `pool_data`=0, `out_valid`=0, `out_data`=0, `out_last`=0, state=FILL, all counters 0. The first cycle after reset is released shows `in_ready`=1.
- Latency: the last fill pixel is accepted at edge T. FEED runs for cycles T+1..T+4. CAPTURE is cycle T+5. `out_valid`=1 from cycle T+6.
- Throughput with `out_ready` held at 1: one window every 6 cycles (4 FEED, 1 CAPTURE, 1 WAIT_OUT).
- Backpressure stalls only in WAIT_OUT. `pool_en` is never asserted while a result is unaccepted, so no pooled value is ever lost.
- `in_ready` is a registered state decode and has no combinational path from `out_ready`.
- Reset mid-operation: immediate return to the reset values. Partial buffer contents are discarded, and the next pixel accepted is treated as pixel (0,0) of a new frame.

## Test plan
- Reset check, MAP_W=4, MAP_H=4: assert `rst` asynchronously in the middle of FEED.
  - Required: `pool_en`, `out_valid` and `in_ready` all drop to 0 without waiting for a clock edge.
  - Required: one cycle after release, `in_ready`=1.
- Single frame, MAP_W=4, MAP_H=4, using the real pooler model. Input pixels 1..16 in raster order.
  - Required outputs, in order: 6, 8, 14, 16.
  - Required: `out_last`=1 only on 16.
  - Required: each FEED burst is exactly 4 cycles, ordered TL, TR, BL, BR.
- Max position sweep. Window values {9,0,0,0}, {0,9,0,0}, {0,0,9,0}, {0,0,0,9}.
  - Required: every result is 9, confirming that no phase is dropped and that the pooler is cleared between windows.
- Backpressure. Hold `out_ready`=0 for 10 cycles after the first result.
  - Required: `out_data`=6 is held stable.
  - Required: `pool_en`=0 throughout the stall.
  - Required: the next FEED begins the cycle after the handshake.
- Input gaps. Toggle `in_valid` randomly during FILL.
  - Required: the same 6, 8, 14, 16 results.
  - Required: `in_ready`=0 for the whole of FEED, CAPTURE and WAIT_OUT.
- Two back-to-back frames, MAP_W=28, MAP_H=28, random unsigned data.
  - Required: 196 results per frame that match a reference 2x2 max.
  - Required: `out_last` is asserted exactly twice.
